// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller and its register-load master:
// default register map, error codes and the sequencing state enum.
package tlc_pkg;

    localparam int TLC_ADDR_RED    = 0;
    localparam int TLC_ADDR_YELLOW = 1;
    localparam int TLC_ADDR_GREEN  = 2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ZERO    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_RED,
        ST_WR_YELLOW,
        ST_WR_GREEN,
        ST_DONE,
        ST_ERR
    } tlc_state_e;

endpackage

// File: rtl/tlc_cfg_master_if.sv
// Register-load bus between the configuration master and the traffic-light controller.
interface tlc_cfg_master_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output addr, output data, output valid, input ready);
    modport slave  (input addr, input data, input valid, output ready);

endinterface

// File: rtl/tlc_cfg_master.sv
// Writes red/yellow/green durations into the controller registers with a ready handshake,
// rejecting zero durations and aborting writes that stall for TIMEOUT_CYCLES cycles.
module tlc_cfg_master
    import tlc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_RED       = TLC_ADDR_RED,
    parameter int ADDR_YELLOW    = TLC_ADDR_YELLOW,
    parameter int ADDR_GREEN     = TLC_ADDR_GREEN,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] t_red,
    input  logic [DATA_WIDTH-1:0] t_yellow,
    input  logic [DATA_WIDTH-1:0] t_green,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    tlc_cfg_master_if.master      bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tlc_state_e            state_q, state_d;
    logic [CNT_W-1:0]      stall_q, stall_d;
    logic [DATA_WIDTH-1:0] sh_red_q, sh_red_d;
    logic [DATA_WIDTH-1:0] sh_yellow_q, sh_yellow_d;
    logic [DATA_WIDTH-1:0] sh_green_q, sh_green_d;
    logic                  capture;

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        err_code_d = err_code_q;
        capture    = 1'b0;
        case (state_q)
            // DONE/ERR last one cycle and accept start like IDLE, so sequences can run back-to-back
            ST_IDLE, ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                if (start) begin
                    err_code_d = ERR_NONE;
                    stall_d    = '0;
                    if ((t_red == '0) || (t_yellow == '0) || (t_green == '0)) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_ZERO;
                    end else begin
                        state_d = ST_WR_RED;
                        capture = 1'b1;
                    end
                end
            end
            ST_WR_RED, ST_WR_YELLOW, ST_WR_GREEN: begin
                // valid is high throughout every WR state, so ready alone marks a transfer
                if (bus.ready) begin
                    stall_d = '0;
                    case (state_q)
                        ST_WR_RED:    state_d = ST_WR_YELLOW;
                        ST_WR_YELLOW: state_d = ST_WR_GREEN;
                        default:      state_d = ST_DONE;
                    endcase
                end else if (stall_q == CNT_LAST) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_red_d    = capture ? t_red    : sh_red_q;
        sh_yellow_d = capture ? t_yellow : sh_yellow_q;
        sh_green_d  = capture ? t_green  : sh_green_q;
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it
    always_comb begin
        valid_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        case (state_d)
            ST_WR_RED: begin
                valid_d = 1'b1;
                addr_d  = ADDR_WIDTH'(ADDR_RED);
                data_d  = sh_red_d;
            end
            ST_WR_YELLOW: begin
                valid_d = 1'b1;
                addr_d  = ADDR_WIDTH'(ADDR_YELLOW);
                data_d  = sh_yellow_d;
            end
            ST_WR_GREEN: begin
                valid_d = 1'b1;
                addr_d  = ADDR_WIDTH'(ADDR_GREEN);
                data_d  = sh_green_d;
            end
            default: ;
        endcase
        busy_d  = valid_d;
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stall_q    <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    // Shadow values are only consumed after a capture, so they need no reset
    always_ff @(posedge clk) begin
        sh_red_q    <= sh_red_d;
        sh_yellow_q <= sh_yellow_d;
        sh_green_q  <= sh_green_d;
    end

    assign bus.valid = valid_q;
    assign bus.addr  = addr_q;
    assign bus.data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_tlc_cfg_master.sv
// Bench for tlc_cfg_master: queue-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tlc_cfg_master;
    import tlc_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] t_red = 8'd0, t_yellow = 8'd0, t_green = 8'd0;
    logic       busy, done, error;
    logic [1:0] err_code;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    tlc_cfg_master_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();
    assign bus.ready = ready;

    tlc_cfg_master #(
        .ADDR_WIDTH(3), .DATA_WIDTH(8),
        .ADDR_RED(0), .ADDR_YELLOW(1), .ADDR_GREEN(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .t_red(t_red), .t_yellow(t_yellow), .t_green(t_green),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pending writes as a queue; bus shows the head, a pop is an accepted write.
    typedef struct { int a; int d; } wr_t;
    wr_t mq[$];
    int  m_stall = 0;
    bit  m_done = 1'b0;
    bit  m_err = 1'b0;
    int  m_code = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_stall = 0; m_done = 1'b0; m_err = 1'b0; m_code = 0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (mq.size() > 0) begin
                if (ready) begin
                    void'(mq.pop_front());
                    m_stall = 0;
                    if (mq.size() == 0) m_done = 1'b1;
                end else begin
                    m_stall++;
                    if (m_stall == TO) begin
                        mq.delete();
                        m_err  = 1'b1;
                        m_code = 2;
                    end
                end
            end else if (start) begin
                m_code  = 0;
                m_stall = 0;
                if (t_red == 0 || t_yellow == 0 || t_green == 0) begin
                    m_err  = 1'b1;
                    m_code = 1;
                end else begin
                    mq.push_back('{0, int'(t_red)});
                    mq.push_back('{1, int'(t_yellow)});
                    mq.push_back('{2, int'(t_green)});
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("valid", 32'(bus.valid), 32'(mq.size() > 0));
            chk("busy", 32'(busy), 32'(mq.size() > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            if (mq.size() > 0) begin
                chk("addr", 32'(bus.addr), 32'(mq[0].a));
                chk("data", 32'(bus.data), 32'(mq[0].d));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic go(input logic [7:0] r, input logic [7:0] y, input logic [7:0] g);
        t_red = r; t_yellow = y; t_green = g;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [7:0] rv();
        return ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endfunction

    initial begin
        int n;
        int nd;
        int nb;
        int sr;

        cyc(); cyc();
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_addr", 32'(bus.addr), 0);
        chk("rst_data", 32'(bus.data), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        ready = 1'b1;

        // Ready high, (3,1,5)
        go(8'd3, 8'd1, 8'd5);
        chk("s1_red_addr", 32'(bus.addr), 0);
        chk("s1_red_data", 32'(bus.data), 3);
        chk("s1_busy", 32'(busy), 1);
        cyc();
        chk("s1_yel_addr", 32'(bus.addr), 1);
        chk("s1_yel_data", 32'(bus.data), 1);
        cyc();
        chk("s1_grn_addr", 32'(bus.addr), 2);
        chk("s1_grn_data", 32'(bus.data), 5);
        cyc();
        chk("s1_done", 32'(done), 1);
        chk("s1_busy_end", 32'(busy), 0);
        cyc();
        chk("s1_done_pulse", 32'(done), 0);

        // Yellow stalled two cycles, inputs changed after start
        go(8'd3, 8'd1, 8'd5);
        t_red = 8'd9; t_yellow = 8'd9; t_green = 8'd9;
        cyc();
        ready = 1'b0;
        cyc();
        chk("s2_hold_addr", 32'(bus.addr), 1);
        chk("s2_hold_data", 32'(bus.data), 1);
        cyc();
        chk("s2_hold2_data", 32'(bus.data), 1);
        ready = 1'b1;
        cyc();
        chk("s2_grn_data", 32'(bus.data), 5);
        cyc();
        chk("s2_done", 32'(done), 1);
        cyc();

        // Zero duration
        go(8'd4, 8'd0, 8'd7);
        chk("s3_error", 32'(error), 1);
        chk("s3_code", 32'(err_code), 1);
        chk("s3_valid", 32'(bus.valid), 0);
        cyc();
        chk("s3_error_pulse", 32'(error), 0);
        chk("s3_code_hold", 32'(err_code), 1);

        // Full timeout
        ready = 1'b0;
        go(8'd3, 8'd1, 8'd5);
        n = 0;
        while (bus.valid && n < 40) begin
            n++;
            chk("s4_addr", 32'(bus.addr), 0);
            cyc();
        end
        chk("s4_valid_cycles", 32'(n), 16);
        chk("s4_error", 32'(error), 1);
        chk("s4_code", 32'(err_code), 2);
        ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("s4_no_retry", 32'(bus.valid), 0);
        end

        // Ready rises in the last stalled cycle
        ready = 1'b0;
        go(8'd3, 8'd1, 8'd5);
        repeat (15) cyc();
        ready = 1'b1;
        cyc();
        chk("s4b_yel_addr", 32'(bus.addr), 1);
        chk("s4b_no_error", 32'(error), 0);
        cyc(); cyc();
        chk("s4b_done", 32'(done), 1);
        chk("s4b_code", 32'(err_code), 0);
        cyc();

        // Reset in WR_GREEN
        go(8'd3, 8'd1, 8'd5);
        cyc(); cyc();
        chk("s5_grn_addr", 32'(bus.addr), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(bus.valid), 0);
        chk("s5_rst_busy", 32'(busy), 0);
        chk("s5_rst_data", 32'(bus.data), 0);
        cyc();
        rst_n = 1'b1;
        go(8'd4, 8'd2, 8'd7);
        chk("s5_red_data", 32'(bus.data), 4);
        cyc();
        chk("s5_yel_data", 32'(bus.data), 2);
        cyc();
        chk("s5_grn_data", 32'(bus.data), 7);
        cyc();
        chk("s5_done", 32'(done), 1);
        chk("s5_code", 32'(err_code), 0);

        // start held high: back-to-back every 4 cycles
        t_red = 8'd1; t_yellow = 8'd2; t_green = 8'd3;
        start = 1'b1;
        nd = 0; nb = 0;
        repeat (12) begin
            cyc();
            if (done) nd++;
            if (busy) nb++;
        end
        start = 1'b0;
        chk("s6_done_count", 32'(nd), 3);
        chk("s6_busy_count", 32'(nb), 9);
        cyc(); cyc();

        // Randomized traffic
        sr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            if (sr > 0) begin
                ready = 1'b0;
                sr--;
            end else if ($urandom_range(0, 39) == 0) begin
                sr = $urandom_range(10, 20);
                ready = 1'b0;
            end else begin
                ready = ($urandom_range(0, 3) != 0);
            end
            start = ($urandom_range(0, 3) == 0);
            t_red = rv();
            t_yellow = rv();
            t_green = rv();
            cyc();
        end
        start = 1'b0;
        ready = 1'b1;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
